// File: rtl/serial_to_parallel.sv
// serial_to_parallel
//   Deserializer: takes a one-bit stream over a valid/ready handshake and packs it,
//   LSB first, into DATA_W-bit words on a valid/ready parallel output. s_last_i
//   closes a word early. One completed word can be parked in the assembly register
//   while another sits in the output holding register, so at most two words are
//   buffered.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   s_valid_i  serial bit valid
//   s_data_i   serial bit
//   s_last_i   final bit of the current word
//   s_ready_o  a serial bit can be accepted this cycle
//   p_valid_o  parallel word valid
//   p_data_o   assembled word, bit k is the k-th bit received
//   p_len_o    number of valid bits in p_data_o (1..DATA_W)
//   p_ready_i  consumer takes the word this cycle
module serial_to_parallel #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid_i,
    input  logic              s_data_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    output logic              p_valid_o,
    output logic [DATA_W-1:0] p_data_o,
    output logic [LEN_W-1:0]  p_len_o,
    input  logic              p_ready_i
);

    localparam logic StCollect = 1'b0;
    localparam logic StStall   = 1'b1;

    logic              state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [LEN_W-1:0]  hold_len_q, hold_len_d;
    logic              hold_valid_q, hold_valid_d;
    logic [LEN_W-1:0]  pend_len_q, pend_len_d;

    logic              accept;
    logic              drain;
    logic              complete;
    logic [LEN_W-1:0]  word_len;
    logic [DATA_W-1:0] asm_wr;
    logic [DATA_W-1:0] word_mask;
    logic [DATA_W-1:0] word;

    // Outputs come straight from registered state only.
    assign s_ready_o = (state_q == StCollect);
    assign p_valid_o = hold_valid_q;
    assign p_data_o  = hold_data_q;
    assign p_len_o   = hold_len_q;

    assign accept   = s_valid_i & s_ready_o;
    assign drain    = hold_valid_q & p_ready_i;
    assign complete = accept & ((cnt_q == LEN_W'(DATA_W - 1)) | s_last_i);
    assign word_len = cnt_q + LEN_W'(1);

    // Write the incoming bit at position cnt; bits above it may be stale from an
    // earlier longer word, so they are masked off in the delivered word.
    always_comb begin
        asm_wr    = asm_q;
        word_mask = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (LEN_W'(i) == cnt_q) begin
                asm_wr[i] = s_data_i;
            end
            word_mask[i] = (LEN_W'(i) <= cnt_q);
        end
    end

    assign word = asm_wr & word_mask;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        hold_data_d  = hold_data_q;
        hold_len_d   = hold_len_q;
        hold_valid_d = hold_valid_q;
        pend_len_d   = pend_len_q;

        // Taken word empties the holding register unless refilled below.
        if (drain) begin
            hold_valid_d = 1'b0;
        end

        case (state_q)
            StCollect: begin
                if (accept) begin
                    if (complete) begin
                        cnt_d = '0;
                        if (!hold_valid_q || drain) begin
                            hold_data_d  = word;
                            hold_len_d   = word_len;
                            hold_valid_d = 1'b1;
                            asm_d        = '0;
                        end else begin
                            // Holding busy: park the word and stop the serial side.
                            asm_d      = word;
                            pend_len_d = word_len;
                            state_d    = StStall;
                        end
                    end else begin
                        asm_d = asm_wr;
                        cnt_d = word_len;
                    end
                end
            end
            StStall: begin
                if (drain) begin
                    hold_data_d  = asm_q;
                    hold_len_d   = pend_len_q;
                    hold_valid_d = 1'b1;
                    asm_d        = '0;
                    state_d      = StCollect;
                end
            end
            default: begin
                state_d = StCollect;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StCollect;
            cnt_q        <= '0;
            asm_q        <= '0;
            hold_data_q  <= '0;
            hold_len_q   <= '0;
            hold_valid_q <= 1'b0;
            pend_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            hold_data_q  <= hold_data_d;
            hold_len_q   <= hold_len_d;
            hold_valid_q <= hold_valid_d;
            pend_len_q   <= pend_len_d;
        end
    end

endmodule
